// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and widths for the input debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    IDLE_HIGH,
    CHECK_LOW
  } deb_state_t;

  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for one asynchronous bit
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce one input; glitch counter under DEBOUNCE_GLITCH_CNT_EN
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  output logic a_clean,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("input_debouncer: STABLE_CYCLES must be >= 2");
  end

  logic             a_s;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             clean_n, rise_n, fall_n;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_raw),
    .q   (a_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      a_clean <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_clean <= clean_n;
      rise    <= rise_n;
      fall    <= fall_n;
    end
  end

  // cnt counts cycles the candidate level has already held; the commit
  // happens on the cycle that would make it STABLE_CYCLES.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clean_n = a_clean;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (a_s) begin
          state_n = CHECK_HIGH;
          cnt_n   = CNT_W'(1);
        end
      end
      CHECK_HIGH: begin
        if (!a_s) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          clean_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!a_s) begin
          state_n = CHECK_LOW;
          cnt_n   = CNT_W'(1);
        end
      end
      CHECK_LOW: begin
        if (a_s) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          clean_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch;

  assign glitch = ((state == CHECK_HIGH) && !a_s) || ((state == CHECK_LOW) && a_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed and random checks of input_debouncer against a run-length model
module tb_input_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic rst;
  logic a_raw;
  logic a_clean;
  logic rise;
  logic fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  input_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_raw   (a_raw),
    .a_clean (a_clean),
    .rise    (rise),
    .fall    (fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a level is accepted once the synchronised input has differed
  // from the clean level for STABLE consecutive cycles; shorter runs are glitches.
  logic hist[$];
  logic m_clean = 1'b0;
  logic m_rise  = 1'b0;
  logic m_fall  = 1'b0;
  int   m_run   = 0;
  int   m_glitch = 0;

  int edge_no, rise_n, fall_n, first_rise, first_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic begin_scn();
    edge_no = 0; rise_n = 0; fall_n = 0; first_rise = -1; first_fall = -1;
  endtask

  task automatic step(input logic raw, input logic r);
    logic s;
    a_raw = raw;
    rst   = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
      hist.push_back(raw);
      if (hist.size() > 16) void'(hist.pop_front());
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_clean) begin
        m_run++;
        if (m_run == STABLE) begin
          m_clean = s;
          m_rise  = s;
          m_fall  = !s;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    edge_no++;
    @(negedge clk);
    check("a_clean", a_clean, m_clean);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt", glitch_cnt, m_glitch);
`endif
    if (rise === 1'b1) begin
      rise_n++;
      if (first_rise < 0) first_rise = edge_no;
    end
    if (fall === 1'b1) begin
      fall_n++;
      if (first_fall < 0) first_fall = edge_no;
    end
  endtask

  initial begin
    int g0;
    logic lvl;
    rst = 1'b1;
    a_raw = 1'b0;

    // reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_a_clean", a_clean, 1'b0);
    check("reset_rise", rise, 1'b0);
    check("reset_fall", fall, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("reset_glitch", glitch_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // clean rise and fall
    begin_scn();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("clean_rise_edge", first_rise, 6);
    check("clean_rise_count", rise_n, 1);
    check("clean_fall_edge", first_fall, 16);
    check("clean_fall_count", fall_n, 1);

    // short glitch
    begin_scn();
    g0 = m_glitch;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("glitch_no_rise", rise_n, 0);
    check("glitch_no_fall", fall_n, 0);
    check("glitch_clean", a_clean, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count", glitch_cnt, g0 + 1);
`endif

    // threshold: exactly STABLE cycles
    begin_scn();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("thresh_rise_edge", first_rise, 6);
    check("thresh_rise_count", rise_n, 1);
    check("thresh_fall_edge", first_fall, 10);

    // bounce then settle
    begin_scn();
    g0 = m_glitch;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check("bounce_rise_count", rise_n, 1);
    check("bounce_rise_edge", first_rise, 10);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch", glitch_cnt, g0 + 2);
`endif
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // reset mid-check, input still high after release
    begin_scn();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rstmid_no_rise", rise_n, 0);
    check("rstmid_clean", a_clean, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("rstmid_rise_edge", first_rise, 11);
    check("rstmid_rise_count", rise_n, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // reset on the commit edge
    begin_scn();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rstcommit_clean", a_clean, 1'b0);
    check("rstcommit_no_rise", rise_n, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check("rstcommit_rise_edge", first_rise, 12);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // random runs with rare resets
    lvl = 1'b0;
    for (int k = 0; k < 60; k++) begin
      int len;
      lvl = ~lvl;
      len = int'($urandom_range(1, 7));
      for (int j = 0; j < len; j++) step(lvl, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // saturation
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b0); step(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
    end
    check("glitch_saturate", glitch_cnt, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
